// File: rtl/vote_pkg.sv
// vote_pkg: FSM state encoding and default sizing shared by vote_tally and its encoder.
package vote_pkg;

   localparam int N_DEF   = 2;
   localparam int W_DEF   = 4;
   localparam int NCAND   = 2**N_DEF;
   localparam int CNT_MAX = 2**W_DEF - 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OPEN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/vote_tally_onehot_encoder.sv
// onehot_encoder: index of the single set bit of d; onehot flags exactly-one-set, e is 0 otherwise.
module onehot_encoder
   import vote_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [2**N-1:0] d,
   output logic [N-1:0]    e,
   output logic            onehot
);

   logic [N:0]   w_pop;
   logic [N-1:0] w_or;

   // OR of set-bit indices equals the index whenever only one bit is set
   always_comb begin
      w_pop = '0;
      w_or  = '0;
      for (int i = 0; i < 2**N; i++) begin
         w_pop = w_pop + (N+1)'(d[i]);
         if (d[i]) w_or = w_or | N'(i);
      end
   end

   assign onehot = (w_pop == (N+1)'(1));
   assign e      = onehot ? w_or : '0;

endmodule

// File: rtl/vote_tally.sv
// vote_tally: sequential one-hot ballot collector feeding the packed-bid bus of winner-select.
// Define VOTE_TALLY_SAT_EN for saturating counters; the default build wraps.
module vote_tally
   import vote_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                close,
   input  logic                ballot_valid,
   input  logic [2**N-1:0]     ballot,
   output logic                ballot_ready,
   output logic [(2**N)*W-1:0] counts,
   output logic                counts_valid,
   output logic [W-1:0]        invalid_cnt,
   output logic [W+N-1:0]      total_cnt,
   output logic                overflow
);

   localparam int             L_NCAND = 2**N;
   localparam logic [W-1:0]   L_MAX   = '1;
   localparam logic [W+N-1:0] L_TMAX  = '1;

   logic [1:0]         r_state;
   logic [W-1:0]       r_invalid;
   logic [W+N-1:0]     r_total;
   logic               r_overflow;
   logic               w_accept;
   logic               w_clear;
   logic               w_onehot;
   logic [N-1:0]       w_idx;
   logic [L_NCAND-1:0] w_cnt_hit;
   logic               w_inv_inc;
   logic               w_inv_hit;
   logic               w_tot_hit;

   onehot_encoder #(.N(N)) u_enc (
      .d      (ballot),
      .e      (w_idx),
      .onehot (w_onehot)
   );

   assign w_accept  = ballot_valid && (r_state == OPEN);
   assign w_clear   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_inv_inc = w_accept && !w_onehot;
   assign w_inv_hit = w_inv_inc && (r_invalid == L_MAX);
   assign w_tot_hit = w_accept && (r_total == L_TMAX);

   // start is not looked at in OPEN, so start+close there resolves to DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: if (start) r_state <= OPEN;
            OPEN:       if (close) r_state <= DONE;
            default:    r_state <= IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < L_NCAND; gi++) begin : g_cnt
         logic         w_inc;
         logic [W-1:0] r_cnt;

         assign w_inc         = w_accept && w_onehot && (w_idx == N'(gi));
         assign w_cnt_hit[gi] = w_inc && (r_cnt == L_MAX);

         always_ff @(posedge clk) begin
            if (!rst_n || w_clear) begin
               r_cnt <= '0;
`ifdef VOTE_TALLY_SAT_EN
            end else if (w_inc && !w_cnt_hit[gi]) begin
`else
            end else if (w_inc) begin
`endif
               r_cnt <= r_cnt + W'(1);
            end
         end

         assign counts[gi*W +: W] = r_cnt;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n || w_clear) begin
         r_invalid  <= '0;
         r_total    <= '0;
         r_overflow <= 1'b0;
      end else begin
`ifdef VOTE_TALLY_SAT_EN
         if (w_inv_inc && !w_inv_hit) r_invalid <= r_invalid + W'(1);
         if (w_accept && !w_tot_hit)  r_total   <= r_total + (W+N)'(1);
`else
         if (w_inv_inc) r_invalid <= r_invalid + W'(1);
         if (w_accept)  r_total   <= r_total + (W+N)'(1);
`endif
         if ((|w_cnt_hit) || w_inv_hit || w_tot_hit) r_overflow <= 1'b1;
      end
   end

   assign ballot_ready = (r_state == OPEN);
   assign counts_valid = (r_state == DONE);
   assign invalid_cnt  = r_invalid;
   assign total_cnt    = r_total;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed table, hand-written corner sequences and a randomized run against a counting model.
module tb_vote_tally;

   localparam int N    = 2;
   localparam int W    = 4;
   localparam int NC   = 4;
   localparam int CMAX = 15;
   localparam int TMAX = 63;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        close;
   logic        ballot_valid;
   logic [3:0]  ballot;
   logic        ballot_ready;
   logic [15:0] counts;
   logic        counts_valid;
   logic [3:0]  invalid_cnt;
   logic [5:0]  total_cnt;
   logic        overflow;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   vote_tally #(.N(N), .W(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .close        (close),
      .ballot_valid (ballot_valid),
      .ballot       (ballot),
      .ballot_ready (ballot_ready),
      .counts       (counts),
      .counts_valid (counts_valid),
      .invalid_cnt  (invalid_cnt),
      .total_cnt    (total_cnt),
      .overflow     (overflow)
   );

   typedef struct {
      logic        st;
      logic        cl;
      logic        bv;
      logic [3:0]  bal;
      logic [15:0] e_counts;
      logic [3:0]  e_inv;
      logic [5:0]  e_tot;
      logic        e_rdy;
      logic        e_cv;
   } vec_t;

   vec_t tbl[15];

   // Reference model: raw number of increment attempts per counter and poll phase (0 idle, 1 open, 2 done)
   int m_phase;
   int m_raw[NC];
   int m_inv;
   int m_tot;

   function automatic int shown(input int raw, input int mx);
`ifdef VOTE_TALLY_SAT_EN
      return (raw > mx) ? mx : raw;
`else
      return raw % (mx + 1);
`endif
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic cl, input logic bv, input logic [3:0] bal);
      start        = st;
      close        = cl;
      ballot_valid = bv;
      ballot       = bal;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NC; i++) m_raw[i] = 0;
      m_inv = 0;
      m_tot = 0;
   endtask

   task automatic model_step();
      int ones;
      int idx;
      if (!rst_n) begin
         m_phase = 0;
         model_clear();
      end else if (m_phase == 1) begin
         if (ballot_valid) begin
            ones = 0;
            idx  = 0;
            for (int i = 0; i < NC; i++) if (ballot[i]) begin ones++; idx = i; end
            m_tot++;
            if (ones == 1) m_raw[idx]++;
            else m_inv++;
         end
         if (close) m_phase = 2;
      end else if (start) begin
         m_phase = 1;
         model_clear();
      end
   endtask

   task automatic model_check(input int cyc);
      logic [15:0] ec;
      logic        eo;
      ec = '0;
      eo = (m_inv > CMAX) || (m_tot > TMAX);
      for (int i = 0; i < NC; i++) begin
         ec[i*W +: W] = 4'(shown(m_raw[i], CMAX));
         if (m_raw[i] > CMAX) eo = 1'b1;
      end
      chk("rnd_counts", 64'(counts), 64'(ec));
      chk("rnd_invalid", 64'(invalid_cnt), 64'(shown(m_inv, CMAX)));
      chk("rnd_total", 64'(total_cnt), 64'(shown(m_tot, TMAX)));
      chk("rnd_ready", 64'(ballot_ready), 64'(m_phase == 1));
      chk("rnd_cvalid", 64'(counts_valid), 64'(m_phase == 2));
      chk("rnd_overflow", 64'(overflow), 64'(eo));
      $display("rnd %0d: counts=%h inv=%0d tot=%0d rdy=%b cv=%b ovf=%b", cyc, counts, invalid_cnt,
               total_cnt, ballot_ready, counts_valid, overflow);
   endtask

   initial begin
      logic [3:0] exp_c3;
      logic [3:0] rb;
      int         r;

      tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 16'h0000, 4'd0, 6'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0, 6'd0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 16'h0001, 4'd0, 6'd1, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 16'h0101, 4'd0, 6'd2, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 16'h0201, 4'd0, 6'd3, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'b1000, 16'h1201, 4'd0, 6'd4, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 16'h1201, 4'd0, 6'd4, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 16'h1201, 4'd0, 6'd4, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0, 6'd0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 16'h0000, 4'd1, 6'd1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 4'b0110, 16'h0000, 4'd2, 6'd2, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 4'b0001, 16'h0001, 4'd2, 6'd3, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 4'b0000, 16'h0000, 4'd0, 6'd0, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 4'd0, 6'd0, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 4'b0000, 16'h0000, 4'd0, 6'd0, 1'b0, 1'b1};

      // reset state
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'b0000);
      tick();
      tick();
      chk("rst_counts", 64'(counts), 64'h0);
      chk("rst_invalid", 64'(invalid_cnt), 64'h0);
      chk("rst_total", 64'(total_cnt), 64'h0);
      chk("rst_ready", 64'(ballot_ready), 64'h0);
      chk("rst_cvalid", 64'(counts_valid), 64'h0);
      chk("rst_overflow", 64'(overflow), 64'h0);
      $display("reset: counts=%h rdy=%b cv=%b", counts, ballot_ready, counts_valid);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].st, tbl[i].cl, tbl[i].bv, tbl[i].bal);
         tick();
         chk($sformatf("vec%0d_counts", i), 64'(counts), 64'(tbl[i].e_counts));
         chk($sformatf("vec%0d_invalid", i), 64'(invalid_cnt), 64'(tbl[i].e_inv));
         chk($sformatf("vec%0d_total", i), 64'(total_cnt), 64'(tbl[i].e_tot));
         chk($sformatf("vec%0d_ready", i), 64'(ballot_ready), 64'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_cvalid", i), 64'(counts_valid), 64'(tbl[i].e_cv));
         chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'h0);
         $display("vec %0d: st=%b cl=%b bv=%b bal=%b -> counts=%h inv=%0d tot=%0d rdy=%b cv=%b",
                  i, tbl[i].st, tbl[i].cl, tbl[i].bv, tbl[i].bal, counts, invalid_cnt, total_cnt,
                  ballot_ready, counts_valid);
      end

      // 17 votes for candidate 3
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'b0000);
      tick();
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      drive(1'b0, 1'b0, 1'b1, 4'b1000);
      for (int i = 0; i < 17; i++) tick();
      drive(1'b0, 1'b0, 1'b0, 4'b0000);
      tick();
`ifdef VOTE_TALLY_SAT_EN
      exp_c3 = 4'd15;
`else
      exp_c3 = 4'd1;
`endif
      chk("ovf_cnt3", 64'(counts[15:12]), 64'(exp_c3));
      chk("ovf_others", 64'(counts[11:0]), 64'h0);
      chk("ovf_flag", 64'(overflow), 64'h1);
      chk("ovf_total", 64'(total_cnt), 64'd17);
      $display("overflow seq: counts=%h tot=%0d ovf=%b", counts, total_cnt, overflow);
      drive(1'b0, 1'b1, 1'b0, 4'b0000);
      tick();
      chk("ovf_held_done", 64'(overflow), 64'h1);
      drive(1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      chk("restart_counts", 64'(counts), 64'h0);
      chk("restart_overflow", 64'(overflow), 64'h0);
      chk("restart_total", 64'(total_cnt), 64'h0);
      chk("restart_ready", 64'(ballot_ready), 64'h1);
      $display("restart: counts=%h ovf=%b rdy=%b", counts, overflow, ballot_ready);

      // reset mid-poll after 3 ballots
      drive(1'b0, 1'b0, 1'b1, 4'b0001);
      tick();
      drive(1'b0, 1'b0, 1'b1, 4'b0010);
      tick();
      drive(1'b0, 1'b0, 1'b1, 4'b0100);
      tick();
      chk("midpoll_counts", 64'(counts), 64'h0111);
      chk("midpoll_total", 64'(total_cnt), 64'd3);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 4'b1000);
      tick();
      chk("abort_counts", 64'(counts), 64'h0);
      chk("abort_total", 64'(total_cnt), 64'h0);
      chk("abort_ready", 64'(ballot_ready), 64'h0);
      chk("abort_cvalid", 64'(counts_valid), 64'h0);
      $display("abort: counts=%h tot=%0d rdy=%b cv=%b", counts, total_cnt, ballot_ready, counts_valid);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'b0000);
      tick();

      // randomized run against the model
      m_phase = 0;
      model_clear();
      rst_n = 1'b0;
      model_step();
      tick();
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         r = int'($urandom_range(0, 9));
         if (r < 5) rb = 4'b0001;
         else if (r < 8) rb = 4'(1 << $urandom_range(1, 3));
         else rb = 4'($urandom_range(0, 15));
         drive($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, rb);
         model_step();
         tick();
         model_check(c);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
